// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serialising memory controller: FSM states,
// access width codes, reset level and busy-bit positions.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IF_READ   = 2'd1,
    MEM_READ  = 2'd2,
    MEM_WRITE = 2'd3
  } state_e;

  localparam logic [2:0]  Byte       = 3'd1;
  localparam logic [2:0]  Half       = 3'd2;
  localparam logic [2:0]  Word       = 3'd4;
  localparam logic        RstEnable  = 1'b1;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam int          BusyIfBit  = 0;
  localparam int          BusyMemBit = 1;

  // Width codes 0 and 3 are illegal and fall back to a full word.
  function automatic logic [2:0] width_bytes(input logic [1:0] code);
    logic [2:0] n;
    case (code)
      2'd1:    n = Byte;
      2'd2:    n = Half;
      default: n = Word;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] busy_of(input state_e st);
    logic [1:0] b;
    b = 2'b00;
    case (st)
      IF_READ:             b[BusyIfBit]  = 1'b1;
      MEM_READ, MEM_WRITE: b[BusyMemBit] = 1'b1;
      default:             b = 2'b00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: turns 32-bit fetches and 1/2/4-byte
// loads/stores into sequential transfers on a single byte-wide RAM port.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              branch_flag_in,
  output logic [31:0]       inst_out,
  output logic              inst_done_out,
  output logic [1:0]        busy_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [1:0]        mem_width_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_data_in,
  output logic [31:0]       mem_data_out,
  output logic              mem_done_out,
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic              ram_wr_out
);

  state_e              state_r, state_s;
  logic [2:0]          cnt_r, cnt_s, cnt_inc_s, nbytes_r, nbytes_s;
  logic [ADDR_W-1:0]   addr_r, addr_s, ram_addr_r, ram_addr_s;
  logic [31:0]         wdata_r, wdata_s, rdata_s;
  logic [23:0]         rbuf_r, rbuf_s;
  logic [31:0]         inst_r, inst_s, mem_data_r, mem_data_s;
  logic                inst_done_r, inst_done_s, mem_done_r, mem_done_s;
  logic [1:0]          busy_r, busy_s;
  logic [7:0]          ram_dout_r, ram_dout_s;
  logic                ram_wr_r, ram_wr_s;

  assign cnt_inc_s = cnt_r + 3'd1;

  // Final read word assembled from the shifted-in bytes plus the byte arriving now.
  always_comb begin
    case (nbytes_r)
      Byte:    rdata_s = {24'h00_0000, ram_din_in};
      Half:    rdata_s = {16'h0000, ram_din_in, rbuf_r[23:16]};
      default: rdata_s = {ram_din_in, rbuf_r};
    endcase
  end

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    nbytes_s    = nbytes_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    rbuf_s      = rbuf_r;
    inst_s      = inst_r;
    mem_data_s  = mem_data_r;
    ram_addr_s  = ram_addr_r;
    ram_dout_s  = ram_dout_r;
    inst_done_s = 1'b0;
    mem_done_s  = 1'b0;
    ram_wr_s    = 1'b0;
    if (!rdy_in) begin
      // Frozen: everything holds, but a write strobe must not linger.
      ram_wr_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mem_req_in) begin
            if (mem_we_in) begin
              state_s    = MEM_WRITE;
              ram_wr_s   = 1'b1;
              ram_dout_s = mem_data_in[7:0];
            end else begin
              state_s    = MEM_READ;
            end
            addr_s     = mem_addr_in;
            ram_addr_s = mem_addr_in;
            nbytes_s   = width_bytes(mem_width_in);
            wdata_s    = mem_data_in;
            cnt_s      = 3'd0;
          end else if (if_req_in) begin
            state_s    = IF_READ;
            addr_s     = if_addr_in;
            ram_addr_s = if_addr_in;
            nbytes_s   = Word;
            cnt_s      = 3'd0;
          end else begin
            state_s = IDLE;
          end
        end
        IF_READ, MEM_READ: begin
          if ((state_r == IF_READ) && branch_flag_in) begin
            state_s = IDLE;
          end else if (cnt_inc_s == nbytes_r) begin
            state_s = IDLE;
            if (state_r == IF_READ) begin
              inst_s      = rdata_s;
              inst_done_s = 1'b1;
            end else begin
              mem_data_s  = rdata_s;
              mem_done_s  = 1'b1;
            end
          end else begin
            rbuf_s     = {ram_din_in, rbuf_r[23:8]};
            ram_addr_s = addr_r + ADDR_W'(cnt_inc_s);
            cnt_s      = cnt_inc_s;
          end
        end
        MEM_WRITE: begin
          if (cnt_inc_s == nbytes_r) begin
            state_s    = IDLE;
            mem_done_s = 1'b1;
          end else begin
            ram_addr_s = addr_r + ADDR_W'(cnt_inc_s);
            ram_dout_s = wdata_r[15:8];
            wdata_s    = {8'h00, wdata_r[31:8]};
            ram_wr_s   = 1'b1;
            cnt_s      = cnt_inc_s;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  assign busy_s = busy_of(state_s);

  // State and output registers; reset overrides the ready hold.
  always_ff @(posedge clk_in) begin
    if (rst_in == RstEnable) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      nbytes_r    <= 3'd0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= ZeroWord;
      rbuf_r      <= 24'h00_0000;
      inst_r      <= ZeroWord;
      mem_data_r  <= ZeroWord;
      inst_done_r <= 1'b0;
      mem_done_r  <= 1'b0;
      busy_r      <= 2'b00;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_dout_r  <= 8'h00;
      ram_wr_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      nbytes_r    <= nbytes_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      rbuf_r      <= rbuf_s;
      inst_r      <= inst_s;
      mem_data_r  <= mem_data_s;
      inst_done_r <= inst_done_s;
      mem_done_r  <= mem_done_s;
      busy_r      <= busy_s;
      ram_addr_r  <= ram_addr_s;
      ram_dout_r  <= ram_dout_s;
      ram_wr_r    <= ram_wr_s;
    end
  end

  assign inst_out      = inst_r;
  assign inst_done_out = inst_done_r;
  assign busy_out      = busy_r;
  assign mem_data_out  = mem_data_r;
  assign mem_done_out  = mem_done_r;
  assign ram_addr_out  = ram_addr_r;
  assign ram_dout_out  = ram_dout_r;
  assign ram_wr_out    = ram_wr_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed plus randomized bench for mem_ctrl against a byte-array model of memory.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, if_req, branch, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata, mem_rdata, inst, ram_addr;
  logic [1:0]  mem_width, busy;
  logic        inst_done, mem_done, ram_wr;
  logic [7:0]  ram_din, ram_dout;

  logic [7:0]  ram  [0:65535];
  logic [7:0]  gold [0:65535];
  logic        tb_we = 1'b0;
  logic [15:0] tb_waddr = 16'h0000;
  logic [7:0]  tb_wdata = 8'h00;
  int          n_wr = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_inst = 32'h0;
  logic [31:0] last_mem = 32'h0;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .if_req_in(if_req), .if_addr_in(if_addr), .branch_flag_in(branch),
    .inst_out(inst), .inst_done_out(inst_done), .busy_out(busy),
    .mem_req_in(mem_req), .mem_we_in(mem_we), .mem_width_in(mem_width),
    .mem_addr_in(mem_addr), .mem_data_in(mem_wdata),
    .mem_data_out(mem_rdata), .mem_done_out(mem_done),
    .ram_din_in(ram_din), .ram_dout_out(ram_dout),
    .ram_addr_out(ram_addr), .ram_wr_out(ram_wr)
  );

  always #5 clk = ~clk;

  // Byte RAM: read data follows the presented address; writes land at the edge.
  assign ram_din = ram[ram_addr[15:0]];
  always @(posedge clk) begin
    if (ram_wr) begin
      ram[ram_addr[15:0]] <= ram_dout;
      n_wr <= n_wr + 1;
    end else if (tb_we) begin
      ram[tb_waddr] <= tb_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] v);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = v; gold[a] = v;
    tick();
    tb_we = 1'b0;
  endtask

  // kind: 0 fetch, 1 load, 2 store. Returns in the done-pulse cycle.
  task automatic run_access(input int kind, input logic [31:0] a, input logic [1:0] wc,
                            input logic [31:0] d);
    int n; int wr0; logic [31:0] expv; logic [31:0] ak; logic [1:0] bexp;
    n = (kind == 0) ? 4 : (wc == 2'd1) ? 1 : (wc == 2'd2) ? 2 : 4;
    bexp = (kind == 0) ? 2'b01 : 2'b10;
    if (kind == 0) begin
      if_req = 1'b1; if_addr = a;
    end else begin
      mem_req = 1'b1; mem_we = (kind == 2); mem_width = wc; mem_addr = a; mem_wdata = d;
    end
    tick();
    if_req = 1'b0; mem_req = 1'b0;
    if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom; mem_width = 2'($urandom);
    wr0 = n_wr;
    expv = 32'h0;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      check("ram_addr", ram_addr, ak);
      check("ram_wr", 32'(ram_wr), 32'(kind == 2));
      if (kind == 2) begin
        check("ram_dout", 32'(ram_dout), 32'(d[8*k +: 8]));
        gold[ak[15:0]] = d[8*k +: 8];
      end
      check("busy", 32'(busy), 32'(bexp));
      check("no_done", 32'({inst_done, mem_done}), 32'h0);
      expv = expv | (32'(gold[ak[15:0]]) << (8*k));
      tick();
    end
    check("busy_done", 32'(busy), 32'h0);
    check("ram_wr_done", 32'(ram_wr), 32'h0);
    check("inst_done", 32'(inst_done), 32'(kind == 0));
    check("mem_done", 32'(mem_done), 32'(kind != 0));
    if (kind == 0) begin
      check("inst_out", inst, expv);
      check("mem_hold", mem_rdata, last_mem);
      last_inst = expv;
    end else if (kind == 1) begin
      check("mem_data", mem_rdata, expv);
      check("inst_hold", inst, last_inst);
      last_mem = expv;
    end else begin
      check("write_count", 32'(n_wr - wr0), 32'(n));
      check("mem_hold", mem_rdata, last_mem);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, inst | mem_rdata | ram_addr, 32'h0);
    check(tag, 32'({inst_done, mem_done, busy, ram_wr, ram_dout}), 32'h0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; if_req = 1'b0; branch = 1'b0; mem_req = 1'b0;
    mem_we = 1'b0; mem_width = 2'd0; if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;

    preload(16'h0010, 8'h13); preload(16'h0011, 8'h05);
    preload(16'h0012, 8'h10); preload(16'h0013, 8'h00);
    preload(16'h0020, 8'h8F);
    for (int i = 0; i < 4; i++) preload(16'h0040 + 16'(i), 8'($urandom));
    for (int i = 0; i < 64; i++) preload(16'h0100 + 16'(i), 8'($urandom));
    preload(16'hFFFE, 8'h11); preload(16'hFFFF, 8'h22);
    preload(16'h0000, 8'h33); preload(16'h0001, 8'h44);

    // Plain fetch, then store word and read it back.
    run_access(0, 32'h0000_0010, 2'd0, 32'h0);
    check("fetch_value", inst, 32'h0010_0513);
    run_access(2, 32'h0000_1000, 2'd0, 32'hDEAD_BEEF);
    run_access(1, 32'h0000_1000, 2'd0, 32'h0);
    check("load_back", mem_rdata, 32'hDEAD_BEEF);
    tick();

    // Simultaneous requests: load wins, fetch follows back-to-back.
    mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd1; mem_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    mem_req = 1'b0;
    check("prio_busy", 32'(busy), 32'h2);
    check("prio_addr", ram_addr, 32'h20);
    tick();
    check("prio_done", 32'({mem_done, inst_done}), 32'h2);
    check("prio_data", mem_rdata, 32'h0000_008F);
    tick();
    if_req = 1'b0;
    check("prio_fetch_busy", 32'(busy), 32'h1);
    check("prio_fetch_addr", ram_addr, 32'h10);
    for (int i = 0; i < 4; i++) tick();
    check("prio_fetch_done", 32'(inst_done), 32'h1);
    check("prio_fetch_inst", inst, 32'h0010_0513);
    last_mem = 32'h0000_008F; last_inst = 32'h0010_0513;
    tick();

    // Branch flush two cycles into a fetch.
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    if_req = 1'b0;
    tick();
    branch = 1'b1;
    tick();
    branch = 1'b0;
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_done", 32'(inst_done), 32'h0);
    check("flush_wr", 32'(ram_wr), 32'h0);
    check("flush_hold", inst, last_inst);
    run_access(0, 32'h0000_0040, 2'd0, 32'h0);

    // Branch has no effect on a data access.
    branch = 1'b1;
    run_access(1, 32'h0000_0100, 2'd2, 32'h0);
    branch = 1'b0;
    tick();

    // Ready stall in the middle of a half-word store.
    mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'd2; mem_addr = 32'h200; mem_wdata = 32'h1234_A5C3;
    tick();
    mem_req = 1'b0;
    check("stall_e0_wr", 32'(ram_wr), 32'h1);
    check("stall_e0_dout", 32'(ram_dout), 32'hC3);
    begin
      int wr0;
      wr0 = n_wr;
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        check("stall_wr", 32'(ram_wr), 32'h0);
        check("stall_addr", ram_addr, 32'h200);
        check("stall_dout", 32'(ram_dout), 32'hC3);
        check("stall_busy", 32'(busy), 32'h2);
        check("stall_done", 32'(mem_done), 32'h0);
      end
      rdy = 1'b1;
      tick();
      check("resume_addr", ram_addr, 32'h201);
      check("resume_dout", 32'(ram_dout), 32'hA5);
      check("resume_wr", 32'(ram_wr), 32'h1);
      tick();
      check("resume_done", 32'(mem_done), 32'h1);
      check("resume_wr_end", 32'(ram_wr), 32'h0);
      check("stall_writes", 32'(n_wr - wr0), 32'h2);
    end
    gold[16'h0200] = 8'hC3; gold[16'h0201] = 8'hA5;
    run_access(1, 32'h0000_0200, 2'd2, 32'h0);
    check("stall_readback", mem_rdata, 32'h0000_A5C3);
    tick();

    // Reset in the middle of a load, with ready low.
    mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd0; mem_addr = 32'h104;
    tick();
    mem_req = 1'b0;
    tick();
    rst = 1'b1; rdy = 1'b0;
    tick();
    check_all_zero("reset_mid_load");
    rst = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_idle", 32'({mem_done, inst_done, busy}), 32'h0);
    end
    last_inst = 32'h0; last_mem = 32'h0;

    // Address wrap-around at the top of the space.
    run_access(0, 32'hFFFF_FFFE, 2'd0, 32'h0);
    check("wrap_inst", inst, 32'h4433_2211);

    // Randomized mix, including illegal width codes and back-to-back issue.
    for (int i = 0; i < 40; i++) begin
      run_access(int'($urandom_range(0, 2)),
                 {16'($urandom), 16'h0100 + 16'($urandom_range(0, 60))},
                 2'($urandom), $urandom);
    end
    tick();
    check("final_idle", 32'({mem_done, inst_done, busy, ram_wr}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller sitting directly upstream of the instruction-fetch stage; owns the single byte-wide RAM port.
- Serves 32-bit instruction fetches for the fetch stage and 1/2/4-byte loads and stores for the MEM stage.
- Serialises every access into byte transfers and reports progress on `busy_out` / `inst_done_out`, which the fetch stage consumes.

Parameters:
- ADDR_W, 32, byte address width.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  reset, synchronous, active-high (`RstEnable` = 1'b1).
- rdy_in  input  1  global ready; when 0, all state and outputs hold.
- if_req_in  input  1  fetch request.
- if_addr_in  input  ADDR_W  fetch address.
- branch_flag_in  input  1  flush; aborts an in-flight fetch.
- inst_out  output  32  fetched instruction, little-endian.
- inst_done_out  output  1  one-cycle pulse; `inst_out` valid.
- busy_out  output  2  [0]: fetch in flight; [1]: MEM access in flight.
- mem_req_in  input  1  load/store request.
- mem_we_in  input  1  1 = store, 0 = load.
- mem_width_in  input  2  1, 2 or 4 bytes; 0 and 3 are illegal.
- mem_addr_in  input  ADDR_W  data address.
- mem_data_in  input  32  store data; low bytes are used.
- mem_data_out  output  32  load data, zero-extended.
- mem_done_out  output  1  one-cycle pulse; load data valid or store complete.
- ram_din_in  input  8  RAM read byte; valid the cycle after its address is presented.
- ram_dout_out  output  8  RAM write byte.
- ram_addr_out  output  ADDR_W  RAM byte address.
- ram_wr_out  output  1  1 = write.

Behaviour:
- Reset (`rst_in`=1 at an edge):
  - state = IDLE; byte counter = 0.
  - All outputs 0.
  - Overrides `rdy_in`, aborting any access mid-operation with no done pulse.
- States: IDLE, IF_READ, MEM_READ, MEM_WRITE.
- IDLE:
  - Samples requests each edge.
  - `mem_req_in` has priority over `if_req_in` when both are high.
  - The fetch stage keeps `if_req_in` high while `busy_out`=2'b10, so no pending-fetch register exists.
- Edge E0 (request accepted):
  - Latch address, width and data; counter = 0.
  - Drive `ram_addr_out` = addr.
  - For stores, also drive `ram_wr_out`=1 and `ram_dout_out`=byte0.
- IF_READ:
  - Edge Ek (k=1..3): `ram_addr_out` = addr+k; capture `ram_din_in` into byte k-1.
  - Edge E4: capture byte3, go to IDLE, `inst_done_out`=1 for exactly one cycle, `inst_out` = {b3,b2,b1,b0}.
- MEM_READ:
  - Same sequence with N = `mem_width_in`; last capture at edge EN.
  - `mem_done_out` pulses after EN; unused upper bytes of `mem_data_out` are 0.
- MEM_WRITE:
  - Edge Ek (k=1..N-1): `ram_addr_out` = addr+k, `ram_dout_out` = byte k, `ram_wr_out`=1.
  - Edge EN: `ram_wr_out`=0, `mem_done_out` pulses, go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- `busy_out`:
  - [0]=1 iff state==IF_READ.
  - [1]=1 iff state is MEM_READ or MEM_WRITE.
  - 2'b00 in IDLE, including the done-pulse cycle.
- A new request can be accepted at the edge ending a done-pulse cycle (back-to-back throughput).
- `branch_flag_in`=1 sampled in IF_READ: go to IDLE next edge, no `inst_done_out`, `ram_wr_out` stays 0.
- `branch_flag_in` has no effect on MEM states or in IDLE.
- `branch_flag_in`=1 during an `inst_done_out` cycle: the pulse still occurs; the fetch stage gives branch priority.
- `rdy_in`=0: counter, state, captured bytes and all outputs frozen; `ram_wr_out` is forced 0 while frozen. Resumes seamlessly.
- Outside an active read, `inst_out` and `mem_data_out` hold their last values; done pulses are never longer than one cycle.
- Illegal `mem_width_in` (0 or 3) is treated as 4.

Decomposition:
- Shared defines: state encodings; width codes (`Byte`=1, `Half`=2, `Word`=4); `RstEnable`; `ZeroWord`; busy bit indices.
- Single module; no sub-module warranted.

Test Plan:
- Fetch 0x00000010, RAM bytes 13 05 10 00 -> edges E0..E3 show `ram_addr_out` 0x10..0x13; `inst_done_out`=1 one cycle after E4 with `inst_out`=0x00100513; `busy_out`=01 during fetch.
- Store word 0xDEADBEEF to 0x1000 -> `ram_wr_out`=1 on addrs 0x1000..0x1003 with bytes EF, BE, AD, DE; `mem_done_out` after E4; `busy_out`=10.
- Simultaneous `mem_req_in` (load byte 0x20 = 0x8F) and `if_req_in` -> load served first, `mem_data_out`=0x0000008F after E1; fetch starts at next accepting edge.
- `branch_flag_in`=1 two cycles into a fetch -> IDLE next edge, no `inst_done_out`, new fetch of 0x40 accepted the following edge.
- `rdy_in`=0 for 3 cycles mid store-half -> all outputs frozen with `ram_wr_out`=0; resume completes correctly with 2 writes total.
- `rst_in`=1 mid-load -> next edge all outputs 0, state IDLE, no done pulse.
